// File: rtl/apb3_requester_sequencer.sv
// ---------------------------------------------------------------------------
// apb3_requester_sequencer
//
// APB3 requester engine. Each start_transaction pulse launches a burst of
// Back2BackNum back-to-back transfers at incrementing slot addresses. Write
// bursts drive the pattern DataSeed + slot. Read bursts compare the returned
// data against the same pattern. Independent write and read slot indices wrap
// after SlotsNum slots, so reads revisit slots in the order they were written.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   start_transaction   single-cycle burst request (ignored while busy)
//   write_mode          1 = write burst, 0 = read burst; sampled with start
//   paddr/psel/penable/pwrite/pwdata   registered APB3 request outputs
//   prdata/pready/pslverr              APB3 completer response
//   busy                burst in progress
//   overrun             sticky flag: start seen while busy
//   mismatch_count      saturating count of read-compare failures
//   slverr_count        saturating count of transfers completed with pslverr
//   timeout_count       saturating count of transfers aborted on timeout
// ---------------------------------------------------------------------------
module apb3_requester_sequencer #(
  parameter int unsigned             AddressWidth  = 20,
  parameter int unsigned             DataWidth     = 32,
  parameter logic [AddressWidth-1:0] BaseAddress   = '0,
  parameter int unsigned             AddrStride    = 4,
  parameter int unsigned             SlotsNum      = 16,
  parameter int unsigned             Back2BackNum  = 2,
  parameter logic [DataWidth-1:0]    DataSeed      = 32'hA5A5_0000,
  parameter int unsigned             TimeoutCycles = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_transaction,
  input  logic                    write_mode,
  output logic [AddressWidth-1:0] paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             mismatch_count,
  output logic [15:0]             slverr_count,
  output logic [15:0]             timeout_count
);

  localparam int unsigned IdxWidth  = (SlotsNum > 1)      ? $clog2(SlotsNum)      : 1;
  localparam int unsigned BeatWidth = (Back2BackNum > 1)  ? $clog2(Back2BackNum)  : 1;
  localparam int unsigned WaitWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_next;
  logic                  mode_write;       // direction latched at burst start
  logic [BeatWidth-1:0]  beat;
  logic [WaitWidth-1:0]  wait_cnt;         // ACCESS cycles seen with pready low
  logic [IdxWidth-1:0]   wr_idx, rd_idx;

  logic                  xfer_done;        // transfer ends this edge (ready or timeout)
  logic                  timed_out;
  logic                  last_beat;
  logic [IdxWidth-1:0]   cur_idx, idx_inc, setup_idx;
  logic                  setup_write;
  logic [DataWidth-1:0]  expected_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cur_idx       = mode_write ? wr_idx : rd_idx;
  assign idx_inc       = (cur_idx == IdxWidth'(SlotsNum - 1)) ? '0 : cur_idx + IdxWidth'(1);
  assign last_beat     = (beat == BeatWidth'(Back2BackNum - 1));
  assign expected_data = DataSeed + DataWidth'(cur_idx);

  // The slot for the upcoming SETUP: from IDLE it comes from the mode being
  // requested right now; between beats it is the just-advanced index.
  assign setup_write = (state == IDLE) ? write_mode : mode_write;
  assign setup_idx   = (state == IDLE) ? (write_mode ? wr_idx : rd_idx) : idx_inc;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left one
    // unassigned would infer a latch.
    state_next = state;
    xfer_done  = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE:   if (start_transaction) state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          xfer_done = 1'b1;
        end else if (wait_cnt == WaitWidth'(TimeoutCycles - 1)) begin
          xfer_done = 1'b1;
          timed_out = 1'b1;
        end
        if (xfer_done) state_next = (timed_out || last_beat) ? IDLE : SETUP;
      end
      default: state_next = IDLE;
    endcase
  end

  // APB outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      psel           <= 1'b0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      paddr          <= '0;
      pwdata         <= '0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      mode_write     <= 1'b0;
      beat           <= '0;
      wait_cnt       <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      mismatch_count <= '0;
      slverr_count   <= '0;
      timeout_count  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // here samples pre-edge values, independent of statement order.
      psel    <= (state_next != IDLE);
      penable <= (state_next == ACCESS);
      busy    <= (state_next != IDLE);

      if (state == IDLE && start_transaction) begin
        mode_write <= write_mode;
        beat       <= '0;
      end
      if (state != IDLE && start_transaction) overrun <= 1'b1;

      if (state_next == SETUP) begin
        paddr  <= BaseAddress + AddressWidth'(setup_idx) * AddressWidth'(AddrStride);
        pwrite <= setup_write;
        pwdata <= setup_write ? DataSeed + DataWidth'(setup_idx) : '0;
      end

      if (state == SETUP)                    wait_cnt <= '0;
      else if (state == ACCESS && !xfer_done) wait_cnt <= wait_cnt + WaitWidth'(1);

      if (xfer_done) begin
        if (mode_write) wr_idx <= idx_inc;
        else            rd_idx <= idx_inc;
        beat <= beat + BeatWidth'(1);
        if (timed_out) begin
          timeout_count <= sat_inc(timeout_count);
        end else begin
          if (pslverr) slverr_count <= sat_inc(slverr_count);
          if (!mode_write && prdata != expected_data)
            mismatch_count <= sat_inc(mismatch_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb3_requester_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apb3_requester_sequencer
//
// Self-checking bench. The bench plays the APB completer and keeps a
// transaction-level model of the requester: slot indices per direction and
// the expected value of each status counter. Directed steps come first,
// followed by randomized bursts.
// ---------------------------------------------------------------------------
module tb_apb3_requester_sequencer;

  localparam int          AW      = 20;
  localparam int          DW      = 32;
  localparam int          STRIDE  = 4;
  localparam int          SLOTS   = 16;
  localparam int          B2B     = 2;
  localparam logic [31:0] SEED    = 32'hA5A5_0000;
  localparam int          TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_transaction;
  logic          write_mode;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic          busy, overrun;
  logic [15:0]   mismatch_count, slverr_count, timeout_count;

  apb3_requester_sequencer #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .BaseAddress  ('0),
    .AddrStride   (STRIDE),
    .SlotsNum     (SLOTS),
    .Back2BackNum (B2B),
    .DataSeed     (SEED),
    .TimeoutCycles(TIMEOUT)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start_transaction(start_transaction),
    .write_mode       (write_mode),
    .paddr            (paddr),
    .psel             (psel),
    .penable          (penable),
    .pwrite           (pwrite),
    .pwdata           (pwdata),
    .prdata           (prdata),
    .pready           (pready),
    .pslverr          (pslverr),
    .busy             (busy),
    .overrun          (overrun),
    .mismatch_count   (mismatch_count),
    .slverr_count     (slverr_count),
    .timeout_count    (timeout_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_wr, m_rd, m_mis, m_slv, m_to;
  bit m_ovr;

  // Per-beat completer behaviour for the next burst.
  int          beat_waits[B2B];   // pready-low cycles; >= TIMEOUT means never ready
  bit          beat_bad[B2B];     // return beat_val instead of the pattern
  logic [31:0] beat_val[B2B];
  bit          beat_err[B2B];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_mis = 0; m_slv = 0; m_to = 0; m_ovr = 0;
  endtask

  task automatic check_idle_status(input string tag);
    check({tag, "_psel"},     psel,           0);
    check({tag, "_penable"},  penable,        0);
    check({tag, "_busy"},     busy,           0);
    check({tag, "_overrun"},  overrun,        m_ovr);
    check({tag, "_mismatch"}, mismatch_count, m_mis);
    check({tag, "_slverr"},   slverr_count,   m_slv);
    check({tag, "_timeout"},  timeout_count,  m_to);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle_status(tag);
    check({tag, "_pwrite"}, pwrite, 0);
    check({tag, "_paddr"},  paddr,  0);
    check({tag, "_pwdata"}, pwdata, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    model_reset();
    check_reset_outputs("rst");
  endtask

  task automatic set_beat(input int b, input int waits, input bit bad,
                          input logic [31:0] val, input bit err);
    beat_waits[b] = waits;
    beat_bad[b]   = bad;
    beat_val[b]   = val;
    beat_err[b]   = err;
  endtask

  task automatic clear_beats();
    for (int b = 0; b < B2B; b++) set_beat(b, 0, 0, 32'h0, 0);
  endtask

  // One full burst; the bench acts as completer and updates the model.
  // pulse_late re-pulses start on the burst's final ACCESS cycle.
  task automatic run_burst(input bit wr, input bit pulse_late);
    int          idx;
    bit          aborted;
    bit          rdy, ends;
    logic [31:0] pattern, returned;
    start_transaction = 1'b1;
    write_mode        = wr;
    step();
    start_transaction = 1'b0;
    write_mode        = 1'($urandom_range(0, 1));
    aborted = 0;
    for (int b = 0; b < B2B && !aborted; b++) begin
      idx      = wr ? m_wr : m_rd;
      pattern  = SEED + 32'(idx);
      returned = beat_bad[b] ? beat_val[b] : pattern;
      check("setup_psel",    psel,    1);
      check("setup_penable", penable, 0);
      check("setup_paddr",   paddr,   32'(idx * STRIDE));
      check("setup_pwrite",  pwrite,  wr);
      check("setup_pwdata",  pwdata,  wr ? pattern : 32'h0);
      check("setup_busy",    busy,    1);
      step();
      for (int cyc = 0; cyc < TIMEOUT; cyc++) begin
        rdy  = (cyc >= beat_waits[b]);
        ends = rdy || (cyc == TIMEOUT - 1);
        check("access_psel",    psel,    1);
        check("access_penable", penable, 1);
        check("access_paddr",   paddr,   32'(idx * STRIDE));
        check("access_pwdata",  pwdata,  wr ? pattern : 32'h0);
        check("access_busy",    busy,    1);
        pready  = rdy;
        prdata  = rdy ? returned : $urandom;
        pslverr = rdy ? beat_err[b] : 1'($urandom_range(0, 1));
        if (pulse_late && ends && (b == B2B - 1 || !rdy)) begin
          start_transaction = 1'b1;
          write_mode        = 1'($urandom_range(0, 1));
          m_ovr             = 1;
        end
        step();
        start_transaction = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (rdy) begin
          if (!wr && returned != pattern) m_mis++;
          if (beat_err[b]) m_slv++;
          break;
        end else if (ends) begin
          m_to++;
          aborted = 1;
        end
      end
      if (wr) m_wr = (m_wr + 1) % SLOTS;
      else    m_rd = (m_rd + 1) % SLOTS;
    end
    check_idle_status("end");
    step();
    check("post_psel", psel, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn            = 1'b0;
    start_transaction = 1'b1;
    write_mode        = 1'b1;
    prdata            = '0;
    pready            = 1'b0;
    pslverr           = 1'b0;
    model_reset();
    clear_beats();

    // Reset with a start pulse held: start must be ignored.
    step();
    step();
    resetn            = 1'b1;
    start_transaction = 1'b0;
    check_reset_outputs("init");
    step();
    check_reset_outputs("init_idle");

    // Zero-wait write burst: slots 0 and 1.
    run_burst(1'b1, 1'b0);

    // Read burst: beat 0 waits 3 cycles, beat 1 returns a bad word.
    set_beat(0, 3, 0, 32'h0, 0);
    set_beat(1, 0, 1, 32'hDEAD_BEEF, 0);
    run_burst(1'b0, 1'b0);
    check("mismatch_after_bad_read", mismatch_count, 1);
    clear_beats();

    // Timeout on beat 0: burst ends, next write starts at slot 1.
    do_reset();
    set_beat(0, TIMEOUT, 0, 32'h0, 0);
    run_burst(1'b1, 1'b0);
    check("timeout_once", timeout_count, 1);
    clear_beats();
    run_burst(1'b1, 1'b0);

    // Slave error on a write, with a start pulse on the final cycle.
    set_beat(0, 0, 0, 32'h0, 1);
    run_burst(1'b1, 1'b1);
    check("slverr_once", slverr_count, 1);
    check("overrun_set", overrun, 1);
    clear_beats();

    // Nine write bursts after reset: the ninth wraps back to slot 0.
    do_reset();
    for (int n = 0; n < 9; n++) run_burst(1'b1, 1'b0);
    for (int n = 0; n < 2; n++) run_burst(1'b0, 1'b0);

    // Reset during ACCESS, then restart from slot 0.
    start_transaction = 1'b1;
    write_mode        = 1'b1;
    step();
    start_transaction = 1'b0;
    step();
    check("midrst_in_access", penable, 1);
    resetn = 1'b0;
    pready = 1'b1;
    pslverr = 1'b1;
    step();
    resetn  = 1'b1;
    pready  = 1'b0;
    pslverr = 1'b0;
    model_reset();
    check_reset_outputs("midrst");
    run_burst(1'b1, 1'b0);

    // Randomized bursts against the model.
    for (int n = 0; n < 40; n++) begin
      for (int b = 0; b < B2B; b++)
        set_beat(b,
                 ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0),
                 $urandom,
                 ($urandom_range(0, 3) == 0));
      run_burst(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
